// File: rtl/snoop_pkg.sv
// snoop_pkg: shared snoop-port widths, mode encodings and dump FSM states
package snoop_pkg;
   localparam int SNOOP_AW = 8;
   localparam int SNOOP_DW = 8;
   localparam logic SNOOPM_WRITE = 1'b0;
   localparam logic SNOOPM_READ  = 1'b1;
   typedef enum logic [2:0] {IDLE, PAUSE, ADDR, WAIT, EMIT, SUM, DONE} dump_state_t;
endpackage

// File: rtl/snoop_dump.sv
// snoop_dump: pauses the core, reads an address range over the snoop port and
// streams each byte (plus an optional 8-bit modular checksum) on a valid/ready port.
// Ports: clk/reset (async, active-high); start + first_addr/last_addr request a dump;
// snoopa/snoopd/snoopm/snoopp drive the snoop port, snoopq returns read data;
// out_data/out_valid/out_ready is the byte stream; busy and done report progress.
module snoop_dump
   import snoop_pkg::*;
#(
   parameter int PAUSE_CYCLES = 2,
   parameter int CHECKSUM     = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SNOOP_AW-1:0] first_addr,
   input  logic [SNOOP_AW-1:0] last_addr,
   output logic [SNOOP_AW-1:0] snoopa,
   output logic [SNOOP_DW-1:0] snoopd,
   output logic                snoopm,
   output logic                snoopp,
   input  logic [SNOOP_DW-1:0] snoopq,
   output logic [SNOOP_DW-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                busy,
   output logic                done
);
   dump_state_t         state;
   logic [SNOOP_AW-1:0] cnt, last;
   logic [SNOOP_DW-1:0] sum;
   logic [7:0]          pcnt;
   logic                hs;

   assign snoopd = '0;
   assign hs     = out_valid && out_ready;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         last      <= '0;
         sum       <= '0;
         pcnt      <= '0;
         snoopa    <= '0;
         snoopm    <= SNOOPM_WRITE;
         snoopp    <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               cnt    <= first_addr;
               last   <= last_addr;
               sum    <= '0;
               pcnt   <= '0;
               snoopp <= 1'b1;
               busy   <= 1'b1;
               state  <= PAUSE;
            end
            // the read address is registered on leaving PAUSE so it is already
            // on snoopa throughout ADDR, giving the memory its sampling edge
            PAUSE: if (pcnt == 8'(PAUSE_CYCLES)) begin
               snoopa <= cnt;
               snoopm <= SNOOPM_READ;
               state  <= ADDR;
            end else pcnt <= pcnt + 8'd1;
            ADDR: state <= WAIT;
            WAIT: begin
               out_data  <= snoopq;
               out_valid <= 1'b1;
               state     <= EMIT;
            end
            EMIT: if (hs) begin
               sum <= sum + out_data;
               if (cnt != last) begin
                  cnt       <= cnt + 1'b1;
                  snoopa    <= cnt + 1'b1;
                  out_valid <= 1'b0;
                  state     <= ADDR;
               end else if (CHECKSUM != 0) begin
                  out_data <= sum + out_data;
                  state    <= SUM;
               end else begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  snoopp    <= 1'b0;
                  snoopm    <= SNOOPM_WRITE;
                  state     <= DONE;
               end
            end
            SUM: if (hs) begin
               out_valid <= 1'b0;
               done      <= 1'b1;
               snoopp    <= 1'b0;
               snoopm    <= SNOOPM_WRITE;
               state     <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_snoop_dump.sv
// tb_snoop_dump: directed bench for snoop_dump against a synchronous-read memory model
module tb_snoop_dump;
   logic       clk = 1'b0;
   logic       reset, start, start1, out_ready;
   logic [7:0] first_addr, last_addr;
   logic [7:0] snoopa, snoopd, snoopq, out_data;
   logic       snoopm, snoopp, out_valid, busy, done;
   logic [7:0] snoopa1, snoopd1, snoopq1, out_data1;
   logic       snoopm1, snoopp1, out_valid1, busy1, done1;
   logic [7:0] mem [256];
   logic [7:0] got [$];
   logic [7:0] exp [$];
   logic [7:0] prog [13] = '{8'h98, 8'h0c, 8'h14, 8'h03, 8'h92, 8'he8, 8'h0c,
                             8'h18, 8'h82, 8'h92, 8'h92, 8'h82, 8'h60};
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      snoopq  <= mem[snoopa];
      snoopq1 <= mem[snoopa1];
   end

   snoop_dump #(.PAUSE_CYCLES(2), .CHECKSUM(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .first_addr(first_addr), .last_addr(last_addr),
      .snoopa(snoopa), .snoopd(snoopd), .snoopm(snoopm), .snoopp(snoopp), .snoopq(snoopq),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done));

   snoop_dump #(.PAUSE_CYCLES(0), .CHECKSUM(0)) u1 (
      .clk(clk), .reset(reset), .start(start1), .first_addr(first_addr), .last_addr(last_addr),
      .snoopa(snoopa1), .snoopd(snoopd1), .snoopm(snoopm1), .snoopp(snoopp1), .snoopq(snoopq1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1), .done(done1));

   // drives one dump on u0 from a negedge, collecting accepted bytes into got;
   // stall holds out_ready low that many cycles per byte, poke re-pulses start
   task automatic dump(input logic [7:0] f, input logic [7:0] l, input int stall, input int poke,
                       output int stab, output bit tmo);
      logic [7:0] hd, ha;
      bit have;
      int w;
      got.delete();
      stab = 0; tmo = 1; have = 0; w = 0; hd = 0; ha = 0;
      first_addr = f; last_addr = l; start = 1; out_ready = 0;
      @(negedge clk);
      for (int c = 0; c < 3000; c++) begin
         start      = (c == poke);
         first_addr = (c == poke) ? 8'h40 : f;
         last_addr  = (c == poke) ? 8'h41 : l;
         if (done) begin tmo = 0; break; end
         out_ready = 0;
         if (out_valid) begin
            if (!have) begin have = 1; hd = out_data; ha = snoopa; w = 0; end
            else if (out_data !== hd || snoopa !== ha) stab++;
            if (w >= stall) begin out_ready = 1; got.push_back(out_data); have = 0; end
            else w++;
         end
         @(negedge clk);
      end
      start = 0; out_ready = 0; first_addr = f; last_addr = l;
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (2) @(negedge clk);
      checks++; if (snoopa !== 8'h00) begin errors++; $display("FAIL rst_snoopa got %h want 00", snoopa); end
      checks++; if (snoopd !== 8'h00) begin errors++; $display("FAIL rst_snoopd got %h want 00", snoopd); end
      checks++; if ({snoopm, snoopp} !== 2'b00) begin errors++; $display("FAIL rst_mp got %b want 00", {snoopm, snoopp}); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
      checks++; if ({out_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_vbd got %b want 000", {out_valid, busy, done}); end
      checks++; if ({out_valid1, busy1, done1, snoopp1} !== 4'b0000) begin errors++; $display("FAIL rst_u1 got %b want 0000", {out_valid1, busy1, done1, snoopp1}); end
      reset = 0;
      @(negedge clk);
   endtask

   task automatic test_timing;
      first_addr = 8'h00; last_addr = 8'h00; start = 1; out_ready = 0;
      @(negedge clk); start = 0;
      checks++; if ({snoopp, busy, snoopm} !== 3'b110) begin errors++; $display("FAIL tim_e0 got %b want 110", {snoopp, busy, snoopm}); end
      repeat (2) @(negedge clk);
      checks++; if (snoopm !== 1'b0) begin errors++; $display("FAIL tim_e2_snoopm got %b want 0", snoopm); end
      @(negedge clk);
      checks++; if ({snoopm, snoopa} !== 9'h100) begin errors++; $display("FAIL tim_e3_addr got %h want 100", {snoopm, snoopa}); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tim_e4_valid got %b want 0", out_valid); end
      @(negedge clk);
      checks++; if ({out_valid, out_data} !== 9'h198) begin errors++; $display("FAIL tim_e5_byte got %h want 198", {out_valid, out_data}); end
      out_ready = 1;
      @(negedge clk);
      checks++; if ({out_valid, out_data} !== 9'h198) begin errors++; $display("FAIL tim_sum got %h want 198", {out_valid, out_data}); end
      @(negedge clk);
      checks++; if ({done, snoopp, snoopm, out_valid, busy} !== 5'b10001) begin errors++; $display("FAIL tim_done got %b want 10001", {done, snoopp, snoopm, out_valid, busy}); end
      out_ready = 0;
      @(negedge clk);
      checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL tim_idle got %b want 00", {done, busy}); end
   endtask

   task automatic test_program;
      int stab; bit tmo;
      exp.delete();
      foreach (prog[i]) exp.push_back(prog[i]);
      exp.push_back(8'he1);
      dump(8'h00, 8'h0c, 0, -1, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL prog_timeout got %b want 0", tmo); end
      checks++; if (got.size() !== 14) begin errors++; $display("FAIL prog_len got %0d want 14", got.size()); end
      for (int i = 0; i < 14 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL prog_byte%0d got %h want %h", i, got[i], exp[i]); end
      end
      @(negedge clk);
      checks++; if ({done, busy, snoopd} !== 10'h000) begin errors++; $display("FAIL prog_end got %h want 000", {done, busy, snoopd}); end
   endtask

   task automatic test_backpressure;
      int stab; bit tmo;
      dump(8'h00, 8'h0c, 3, -1, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b want 0", tmo); end
      checks++; if (stab !== 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stab); end
      checks++; if (got.size() !== 14) begin errors++; $display("FAIL bp_len got %0d want 14", got.size()); end
      for (int i = 0; i < 14 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_wrap;
      int stab; bit tmo;
      logic [7:0] w [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'haa};
      mem[8'hfe] = 8'h11; mem[8'hff] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;
      dump(8'hfe, 8'h01, 0, -1, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wrap_timeout got %b want 0", tmo); end
      checks++; if (got.size() !== 5) begin errors++; $display("FAIL wrap_len got %0d want 5", got.size()); end
      for (int i = 0; i < 5 && i < got.size(); i++) begin
         checks++; if (got[i] !== w[i]) begin errors++; $display("FAIL wrap_byte%0d got %h want %h", i, got[i], w[i]); end
      end
      mem[8'h00] = 8'h98; mem[8'h01] = 8'h0c;
      @(negedge clk);
   endtask

   task automatic test_single;
      int stab; bit tmo;
      logic [7:0] g1 [$];
      bit seen;
      mem[8'h05] = 8'h92;
      dump(8'h05, 8'h05, 1, -1, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout got %b want 0", tmo); end
      checks++; if (got.size() !== 2) begin errors++; $display("FAIL single_len got %0d want 2", got.size()); end
      for (int i = 0; i < 2 && i < got.size(); i++) begin
         checks++; if (got[i] !== 8'h92) begin errors++; $display("FAIL single_byte%0d got %h want 92", i, got[i]); end
      end
      @(negedge clk);
      seen = 0;
      first_addr = 8'h05; last_addr = 8'h05; start1 = 1; out_ready = 1;
      @(negedge clk); start1 = 0;
      for (int c = 0; c < 100; c++) begin
         if (done1) begin seen = 1; break; end
         if (out_valid1) g1.push_back(out_data1);
         @(negedge clk);
      end
      out_ready = 0;
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL nosum_done got %b want 1", seen); end
      checks++; if (g1.size() !== 1) begin errors++; $display("FAIL nosum_len got %0d want 1", g1.size()); end
      if (g1.size() > 0) begin
         checks++; if (g1[0] !== 8'h92) begin errors++; $display("FAIL nosum_byte got %h want 92", g1[0]); end
      end
      mem[8'h05] = 8'he8;
      @(negedge clk);
   endtask

   task automatic test_mid_start;
      int stab; bit tmo;
      dump(8'h00, 8'h0c, 0, 10, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL mid_timeout got %b want 0", tmo); end
      checks++; if (got.size() !== 14) begin errors++; $display("FAIL mid_len got %0d want 14", got.size()); end
      for (int i = 0; i < 14 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d got %h want %h", i, got[i], exp[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      int stab; bit tmo;
      got.delete();
      first_addr = 8'h00; last_addr = 8'h0c; start = 1; out_ready = 1;
      @(negedge clk); start = 0;
      for (int c = 0; c < 200; c++) begin
         if (got.size() == 3) break;
         if (out_valid) got.push_back(out_data);
         @(negedge clk);
      end
      checks++; if (got.size() !== 3) begin errors++; $display("FAIL rmid_progress got %0d want 3", got.size()); end
      checks++; if (snoopp !== 1'b1) begin errors++; $display("FAIL rmid_pre_snoopp got %b want 1", snoopp); end
      reset = 1;
      #1;
      checks++; if ({snoopa, snoopd, snoopm, snoopp, out_data, out_valid, busy, done} !== 29'h0) begin
         errors++; $display("FAIL rmid_outputs got %h want 0", {snoopa, snoopd, snoopm, snoopp, out_data, out_valid, busy, done});
      end
      @(negedge clk);
      reset = 0; out_ready = 0;
      @(negedge clk);
      dump(8'h00, 8'h0c, 0, -1, stab, tmo);
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %b want 0", tmo); end
      checks++; if (got.size() !== 14) begin errors++; $display("FAIL rmid_len got %0d want 14", got.size()); end
      for (int i = 0; i < 14 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rmid_byte%0d got %h want %h", i, got[i], exp[i]); end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1; start = 0; start1 = 0; out_ready = 0; first_addr = 0; last_addr = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
      foreach (prog[i]) mem[i] = prog[i];
      test_reset;
      test_timing;
      test_program;
      test_backpressure;
      test_wrap;
      test_single;
      test_mid_start;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/snoop_dump.md
# snoop_dump

Hardware read-back engine for the `discus` snoop port: on command it pauses the core, walks an address range of program/data memory through the snoop read path, and streams each byte out on a valid/ready byte interface, followed by an 8-bit checksum. It sits beside the snoop loader, is clocked by the same clock as `snoop_clk`, and is the read-direction counterpart used to verify loaded programs and dump memory after a run.

## Interface
Parameters:
- `PAUSE_CYCLES`, 2: cycles `snoopp` is held high before the first read, letting the core settle.
- `CHECKSUM`, 1: 1 appends the 8-bit modular sum of the dumped bytes; 0 omits it.

Ports:
- `clk`  in  1  sole clock; also drives `discus.snoop_clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `first_addr`  in  8  first address, captured on accepted `start`.
- `last_addr`  in  8  last address inclusive, captured on accepted `start`.
- `snoopa`  out  8  snoop address to `discus`.
- `snoopd`  out  8  snoop write data; constant 0.
- `snoopm`  out  1  snoop mode: 0 = write, 1 = read (no write).
- `snoopp`  out  1  core pause; high from accepted `start` until the dump finishes.
- `snoopq`  in  8  snoop read data, valid one cycle after `snoopa`/`snoopm=1`.
- `out_data`  out  8  dumped byte or checksum.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last byte is accepted.

## Operation
- Reset values: `snoopa`=0, `snoopd`=0, `snoopm`=0, `snoopp`=0, `out_data`=0, `out_valid`=0, `busy`=0, `done`=0.
- States: IDLE, PAUSE, ADDR, WAIT, EMIT, SUM, DONE.
- IDLE: `start`=1 latches `first_addr`/`last_addr`, loads the address counter from `first_addr`, clears the checksum, then moves to PAUSE.
- PAUSE: `snoopp`=1; hold for `PAUSE_CYCLES` cycles, then go to ADDR. `PAUSE_CYCLES`=0 goes directly to ADDR.
- ADDR: drive `snoopa`=counter, `snoopm`=1, then go to WAIT.
- WAIT: register `snoopq` into `out_data`, then go to EMIT.
- EMIT: `out_valid`=1, with `out_data`, `snoopa`, and `snoopm` held stable until the handshake. On handshake, checksum += byte (mod 256).
  - Counter ≠ last: increment mod 256 and go to ADDR.
  - Otherwise: go to SUM if `CHECKSUM`, else DONE.
- SUM: `out_data`=checksum, `out_valid`=1; on handshake go to DONE.
- DONE: `done`=1 and `snoopp`=0 for one cycle, `snoopm` returns to 0, then IDLE.
- Wrap-around: when `last_addr` < `first_addr`, the walk wraps from 0xFF to 0x00. Byte count = ((last − first) mod 256) + 1. `first_addr` == `last_addr` emits exactly one byte.
- `start` while `busy` is ignored and does not disturb the captured range.
- Asynchronous reset mid-dump returns to IDLE immediately with all outputs at reset values; the partial checksum is discarded.
- `snoopd` is never driven nonzero, and `snoopm` is never 0 while `snoopp`=1 after PAUSE, so the dump never writes memory.

## Timing
- `start` is accepted at edge 0; `snoopp`=1 after edge 0.
- First `snoopm`=1/`snoopa` after edge 1+`PAUSE_CYCLES`.
- First `out_valid` after edge 3+`PAUSE_CYCLES` (default 5 cycles).
- Steady-state throughput with `out_ready` held high: one byte per 3 cycles (ADDR, WAIT, EMIT).
- `out_valid` never drops without a handshake; `out_data` never changes while `out_valid && !out_ready`.
- `done` is asserted the cycle after the final handshake; `busy` falls the cycle after `done`.

## Structure
- Shared package `snoop_pkg`:
  - state enum `dump_state_t`;
  - constants `SNOOPM_WRITE`=0 and `SNOOPM_READ`=1;
  - `SNOOP_AW`=8 and `SNOOP_DW`=8, also used by the loader and the benches.
- Single module with no sub-module; the address counter and checksum accumulator are inline registers.

## Test plan
- Load 0x98,0x0c,0x14,0x03,0x92,0xe8,0x0c,0x18,0x82,0x92,0x92,0x82,0x60 at 0x00–0x0C, then dump 0x00..0x0C with `out_ready`=1 → the same 13 bytes, then checksum 0xE1, then one `done` pulse.
- Wrap: memory[0xFE,0xFF,0x00,0x01]=0x11,0x22,0x33,0x44, dump 0xFE..0x01 → 0x11,0x22,0x33,0x44, then checksum 0xAA.
- Backpressure: hold `out_ready` low 3 cycles on every byte → identical stream, `out_data` and `snoopa` stable while stalled, no byte lost or duplicated.
- Single byte: `first_addr`=`last_addr`=0x05 with memory 0x92 → 0x92 then checksum 0x92; with `CHECKSUM`=0 → only 0x92.
- Pulse `start` mid-dump → ignored, stream unchanged. Assert `reset` after the third byte → all outputs zero in the same cycle; a fresh `start` after reset gives a correct full dump.
